// File: rtl/data_mem_io_pkg.sv
// Shared constants for the data-side memory and I/O block.
// I/O register offsets, STATUS bit positions and timer reset values.
package data_mem_io_pkg;

    localparam logic [9:0] IO_LED      = 10'h200;
    localparam logic [9:0] IO_SW       = 10'h204;
    localparam logic [9:0] IO_KEY_EDGE = 10'h208;
    localparam logic [9:0] IO_TCOUNT   = 10'h20C;
    localparam logic [9:0] IO_TCMP     = 10'h210;
    localparam logic [9:0] IO_STATUS   = 10'h214;

    localparam int ST_MATCH = 0;
    localparam int ST_EN    = 1;

    localparam logic [31:0] TCMP_RESET = 32'hFFFF_FFFF;

endpackage

// File: rtl/io_timer.sv
// Prescaled 32-bit timer with compare, sticky match flag and enable.
// Match is evaluated against the count before it increments.
module io_timer
    import data_mem_io_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        we_count,
    input  logic        we_cmp,
    input  logic        we_status,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] cmp,
    output logic [31:0] status,
    output logic        timer_irq
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    logic [PW-1:0] pre;
    logic          en;
    logic          flag;
    logic          tick;
    logic          match;

    assign tick  = en && (pre == PMAX);
    assign match = tick && (count == cmp);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pre <= '0;
        end else if (en) begin
            pre <= tick ? '0 : pre + 1'b1;
        end
    end

    // A load on a tick cycle wins; the prescaler wraps to 0 anyway.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            count <= '0;
        end else if (we_count) begin
            count <= wdata;
        end else if (tick) begin
            count <= count + 32'd1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cmp <= TCMP_RESET;
        end else if (we_cmp) begin
            cmp <= wdata;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            en   <= 1'b0;
            flag <= 1'b0;
        end else begin
            if (we_status) begin
                en <= wdata[ST_EN];
            end
            if (match) begin
                flag <= 1'b1;
            end else if (we_status && wdata[ST_MATCH]) begin
                flag <= 1'b0;
            end
        end
    end

    always_comb begin
        status           = '0;
        status[ST_MATCH] = flag;
        status[ST_EN]    = en;
    end

    assign timer_irq = flag;

endmodule

// File: rtl/data_mem_io.sv
// Data-port memory system: word RAM in the low half of the map,
// LED / switch / key-edge / timer registers in the high half.
module data_mem_io
    import data_mem_io_pkg::*;
#(
    parameter int RAM_WORDS = 128,
    parameter int PRESCALE  = 1
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [9:0]  daddr,
    input  logic [31:0] ddata_w,
    input  logic        d_rw,
    output logic [31:0] ddata_r,
    input  logic [9:0]  sw,
    input  logic [3:0]  key,
    output logic [9:0]  led,
    output logic        timer_irq
);

    localparam int RIW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

    logic [31:0]    ram [RAM_WORDS];
    logic [6:0]     ram_idx;
    logic [RIW-1:0] ram_a;
    logic           ram_hit;
    logic [9:0]     io_addr;

    logic sel_led;
    logic sel_sw;
    logic sel_key;
    logic sel_cnt;
    logic sel_cmp;
    logic sel_st;

    logic [9:0] sw_s1;
    logic [9:0] sw_s2;
    logic [3:0] key_s1;
    logic [3:0] key_s2;
    logic [3:0] key_d;
    logic [3:0] key_edge;
    logic [3:0] key_fall;
    logic [3:0] key_clr;

    logic [31:0] t_count;
    logic [31:0] t_cmp;
    logic [31:0] t_status;

    assign ram_idx = daddr[8:2];
    assign ram_a   = ram_idx[RIW-1:0];
    assign ram_hit = !daddr[9] && ({1'b0, ram_idx} < 8'(RAM_WORDS));
    assign io_addr = {daddr[9:2], 2'b00};

    assign sel_led = daddr[9] && (io_addr == IO_LED);
    assign sel_sw  = daddr[9] && (io_addr == IO_SW);
    assign sel_key = daddr[9] && (io_addr == IO_KEY_EDGE);
    assign sel_cnt = daddr[9] && (io_addr == IO_TCOUNT);
    assign sel_cmp = daddr[9] && (io_addr == IO_TCMP);
    assign sel_st  = daddr[9] && (io_addr == IO_STATUS);

    always_ff @(posedge CLK) begin
        if (d_rw && ram_hit) begin
            ram[ram_a] <= ddata_w;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            led <= '0;
        end else if (d_rw && sel_led) begin
            led <= ddata_w[9:0];
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sw_s1 <= '0;
            sw_s2 <= '0;
        end else begin
            sw_s1 <= sw;
            sw_s2 <= sw_s1;
        end
    end

    // Key flops reset high so releasing reset cannot look like a press.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            key_s1 <= '1;
            key_s2 <= '1;
            key_d  <= '1;
        end else begin
            key_s1 <= key;
            key_s2 <= key_s1;
            key_d  <= key_s2;
        end
    end

    assign key_fall = key_d & ~key_s2;
    assign key_clr  = (d_rw && sel_key) ? ddata_w[3:0] : 4'h0;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            key_edge <= '0;
        end else begin
            key_edge <= (key_edge & ~key_clr) | key_fall;
        end
    end

    io_timer #(
        .PRESCALE (PRESCALE)
    ) u_timer (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .we_count  (d_rw && sel_cnt),
        .we_cmp    (d_rw && sel_cmp),
        .we_status (d_rw && sel_st),
        .wdata     (ddata_w),
        .count     (t_count),
        .cmp       (t_cmp),
        .status    (t_status),
        .timer_irq (timer_irq)
    );

    always_comb begin
        ddata_r = '0;
        unique case (1'b1)
            ram_hit: ddata_r = ram[ram_a];
            sel_led: ddata_r = {22'b0, led};
            sel_sw:  ddata_r = {22'b0, sw_s2};
            sel_key: ddata_r = {28'b0, key_edge};
            sel_cnt: ddata_r = t_count;
            sel_cmp: ddata_r = t_cmp;
            sel_st:  ddata_r = t_status;
            default: ddata_r = '0;
        endcase
    end

endmodule

// File: doc/data_mem_io.md
# data_mem_io

Data-side memory system for the pipelined RV32I core: it receives the core's data port (`daddr`, `ddata_w`, `d_rw`) and returns `ddata_r`. It decodes each access to either an on-chip word RAM or a bank of memory-mapped I/O registers. The I/O bank holds LEDs, synchronized switches, sticky key-edge flags and a prescaled timer with compare.

## Interface
- `RAM_WORDS`, default 128: RAM depth in 32-bit words. Must be ≤128, since the RAM half of the map is 512 bytes.
- `PRESCALE`, default 1: timer advances once every `PRESCALE` cycles. Must be ≥1.
- `CLK` in 1: single clock, rising edge.
- `RESET_N` in 1: asynchronous, active-low reset.
- `daddr` in 10: byte address from the core's MEM stage.
- `ddata_w` in 32: write data.
- `d_rw` in 1: 1 = write this cycle, 0 = read.
- `ddata_r` out 32: read data, valid combinationally in the same cycle as `daddr`.
- `sw` in 10: asynchronous slide switches.
- `key` in 4: asynchronous push buttons, active-low.
- `led` out 10: LED register.
- `timer_irq` out 1: level output, equal to `STATUS[0]`.

## Operation
- Word access only. `daddr[1:0]` is ignored; no byte or halfword lanes.
- `daddr[9]`=0 selects RAM.
  - Word index is `daddr[8:2]`.
  - An index ≥`RAM_WORDS` reads 0 and ignores writes.
- `daddr[9]`=1 selects I/O, decoded on `daddr[9:2]`:
  - 0x200 LED: R/W, bits [9:0]; upper bits read 0.
  - 0x204 SW: read-only. Returns the 2-flop-synchronized `sw`, zero-extended.
  - 0x208 KEY_EDGE: bit i sets on a falling edge of synchronized `key[i]`. Write-1-to-clear per bit.
  - 0x20C TCOUNT: 32-bit counter. A write loads `ddata_w`.
  - 0x210 TCMP: compare value, R/W.
  - 0x214 STATUS: bit0 = match flag, write-1-to-clear. bit1 = timer enable, R/W.
  - Any other I/O address reads 0 and ignores writes.
- Writes commit on the rising edge where `d_rw`=1. Reads have no side effects.
- Key edge detection uses a 2-flop synchronizer plus one delay flop, per bit. A falling edge is the delayed bit = 1 while the synchronized bit = 0.
- Timer:
  - When enabled, a prescaler counts 0..`PRESCALE`-1. On wrap, TCOUNT increments modulo 2^32, wrapping 0xFFFFFFFF→0.
  - When disabled, both the prescaler and TCOUNT hold.
- Match: in any cycle where the timer is enabled, the prescaler wraps, and TCOUNT == TCMP, the match flag sets on that edge. The compare uses the pre-increment value.
- Simultaneous events:
  - A TCOUNT write in the same cycle as an increment: the write wins, and the prescaler resets to 0.
  - A W1C of the match flag in the same cycle as a new match: set wins.
  - A W1C of a KEY_EDGE bit in the same cycle as a new edge on that bit: set wins.
  - A STATUS write updates the enable and clears the flag in the same edge. The enable bit is written directly, not W1C.
- Reset (asynchronous, any time):
  - `led`=0, TCOUNT=0, TCMP=0xFFFFFFFF, STATUS=0, KEY_EDGE=0, prescaler=0.
  - All synchronizer flops reset to 0; the key synchronizers and delay flops reset to 1, so release from reset creates no spurious edge.
  - `timer_irq`=0.
  - RAM contents are not reset.

## Timing
- Read latency 0: `ddata_r` is a combinational function of `daddr` and the current register/RAM state.
- Write latency 1: the new value is visible to a read in the cycle after the write edge.
- `sw` → SW register: 2 cycles. `key` fall → KEY_EDGE bit set: 3 edges.
- `timer_irq` rises 1 cycle after the qualifying match cycle.
- There are no stalls and no handshake; every cycle completes one access.

## Structure
- Package `data_mem_io_pkg` holds:
  - the I/O offset localparams (`IO_LED`, `IO_SW`, `IO_KEY_EDGE`, `IO_TCOUNT`, `IO_TCMP`, `IO_STATUS`);
  - the STATUS bit indices;
  - the TCMP reset constant.
- Sub-module `io_timer` contains the prescaler, TCOUNT, TCMP, match flag and enable. It exposes write strobes, write data, count/compare/status read values, and `timer_irq`.
- The RAM is an inferred array with asynchronous read (LUT RAM). The top level holds the address decode, the read mux, and the LED/SW/KEY logic.

## Test plan
- RAM round-trip: write 0xDEADBEEF to 0x004 and 0x12345678 to 0x1FC, then read both → values returned. Read 0x006 → 0xDEADBEEF, since the low bits are ignored.
- LED/unmapped: write 0xFFFFFFFF to 0x200 → `led`=0x3FF and readback 0x000003FF. Write to 0x3F0 → no state change; read 0x3F0 → 0.
- Switch and key:
  - Set `sw`=0x2A5 → SW reads 0x2A5 from the 2nd edge on.
  - Pulse `key[2]` low for 5 cycles → KEY_EDGE=0x4 and stays set. Write 0x4 → 0.
  - Edge and W1C in the same cycle → bit stays 1.
- Timer with `PRESCALE`=4:
  - Write TCMP=3, then STATUS=0x2 → TCOUNT reaches 3 after 12 cycles. `timer_irq`=1 one cycle after the match cycle.
  - Write STATUS=0x3 → flag clears, enable stays 1.
- Wrap and collision: load TCOUNT=0xFFFFFFFF with the timer enabled → it wraps to 0. A TCOUNT write on an increment cycle → the written value wins.
- Asynchronous reset mid-run with the timer enabled and `led`=0x155: all outputs go to reset values immediately, TCMP reads 0xFFFFFFFF, and RAM data written before the reset reads back unchanged.
